window_scan_ctrl: RTL and testbench

Sequencer for the 4x4 `windowStorage` line buffer. It accepts a raster pixel stream over a valid/ready handshake and drives the storage write port (`dataIn`/`we`). It tracks column and row position in the frame and flags each cycle in which the storage's 16 outputs hold a complete, in-frame 4x4 window. The block sits between the pixel source and the window consumer. It back-pressures the source whenever the consumer holds a window, because any storage write shifts the window.

---
 rtl/window_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_window_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: raster pixel sequencer for the 4x4 windowStorage
// line buffer; drives its write port and flags complete windows.
module window_scan_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [7:0]    ws_data,
  output logic          ws_we,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_3    = CW'(3);
  localparam logic [RW-1:0] ROW_3    = RW'(3);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic          s1_valid_q, s1_valid_d;
  logic [7:0]    s1_pix_q, s1_pix_d;
  logic [CW-1:0] s1_col_q, s1_col_d;
  logic [RW-1:0] s1_row_q, s1_row_d;

  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;

  logic accept;
  logic last_pix;
  logic win_hit;

  // A write shifts the storage, so it waits until the held window is taken.
  assign ws_we      = s1_valid_q && (!win_valid_q || win_ready);
  assign ws_data    = s1_pix_q;
  assign pix_ready  = (state_q == ACTIVE) && (!s1_valid_q || ws_we);
  assign accept     = pix_valid && pix_ready;
  assign last_pix   = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign win_hit    = (s1_col_q >= COL_3) && (s1_row_q >= ROW_3);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DRAIN) && !s1_valid_q && !win_valid_q;
  assign win_valid  = win_valid_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;

  // Frame sequencing and raster position of the next accepted pixel.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_pix) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !win_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1 holding register and window flag update.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_pix_d    = s1_pix_q;
    s1_col_d    = s1_col_q;
    s1_row_d    = s1_row_q;
    win_valid_d = win_valid_q;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
    if (ws_we) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_pix_d   = pix_in;
      s1_col_d   = col_q;
      s1_row_d   = row_q;
    end
    if (ws_we) begin
      win_valid_d = win_hit;
      if (win_hit) begin
        win_col_d = s1_col_q - COL_3;
        win_row_d = s1_row_q - ROW_3;
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s1_valid_q  <= s1_valid_d;
      s1_pix_q    <= s1_pix_d;
      s1_col_q    <= s1_col_d;
      s1_row_q    <= s1_row_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb_window_scan_ctrl: scoreboard bench for window_scan_ctrl
// on an 8x6 frame.
module tb_window_scan_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 3;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [7:0]    ws_data;
  logic          ws_we;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          busy;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  int acc_q[$];
  int win_q[$];

  window_scan_ctrl #(
    .IMG_W(W),
    .IMG_H(H),
    .CW(CW),
    .RW(RW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pix_in(pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .ws_data(ws_data),
    .ws_we(ws_we),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_col(win_col),
    .win_row(win_row),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 0);
    chk({tag, "_ws_we"}, 32'(ws_we), 0);
    chk({tag, "_win_valid"}, 32'(win_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_ws_data"}, 32'(ws_data), 0);
    chk({tag, "_win_col"}, 32'(win_col), 0);
    chk({tag, "_win_row"}, 32'(win_row), 0);
  endtask

  task automatic run_frame(input bit bubbles,
                           input bit stall,
                           input int rst_after,
                           input int start_at);
    int k = 0;
    int nwin = 0;
    int nfd = 0;
    int cyc = 0;
    int post = 0;
    int last_acc = 0;
    int fd_cyc = 0;
    int stall_left = 0;
    int p;
    int e;
    bit stall_trig = 0;
    bit prev_wr = 0;
    bit prev_exp = 0;
    bit done = 0;
    bit aborted = 0;
    acc_q.delete();
    win_q.delete();
    @(posedge clk);
    #1 start = 1'b1;
    win_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pix_in = '0;
    pix_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (prev_wr) chk("wv_after_wr", 32'(win_valid), 32'(prev_exp));
      if (stall_left > 0) begin
        chk("stall_wv", 32'(win_valid), 1);
        chk("stall_col", 32'(win_col), 2);
        chk("stall_row", 32'(win_row), 1);
        chk("stall_we", 32'(ws_we), 0);
        if (stall_left < 10) chk("stall_rdy", 32'(pix_ready), 0);
      end
      if (win_valid && win_ready) begin
        chk("win_q_nonempty", 32'(win_q.size() > 0), 1);
        if (win_q.size() > 0) begin
          e = win_q.pop_front();
          chk("win_col", 32'(win_col), 32'(e >> 8));
          chk("win_row", 32'(win_row), 32'(e & 255));
        end
        nwin++;
      end
      prev_wr = ws_we;
      prev_exp = 1'b0;
      if (ws_we) begin
        chk("acc_q_nonempty", 32'(acc_q.size() > 0), 1);
        if (acc_q.size() > 0) begin
          p = acc_q.pop_front();
          chk("ws_data", 32'(ws_data), 32'(p & 255));
          if ((p % W) >= 3 && (p / W) >= 3) begin
            win_q.push_back((((p % W) - 3) << 8) | ((p / W) - 3));
            prev_exp = 1'b1;
          end
          if (stall && p == 37) stall_trig = 1'b1;
        end
      end
      if (pix_valid && pix_ready) begin
        acc_q.push_back(k);
        k++;
        last_acc = cyc;
      end
      if (frame_done) begin
        nfd++;
        fd_cyc = cyc;
      end
      if (nfd > 0) post++;
      if (post == 2) chk("busy_after_done", 32'(busy), 0);
      if (post == 3) done = 1'b1;
      if (rst_after > 0 && k >= rst_after) begin
        reset = 1'b0;
        pix_valid = 1'b0;
        win_ready = 1'b1;
        #1;
        chk_zero("rst_mid");
        aborted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      pix_valid = (k < W * H) &&
                  (bubbles ? 1'($urandom_range(0, 1)) : 1'b1);
      pix_in = 8'(k);
      if (stall_trig) begin
        stall_left = 10;
        stall_trig = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      win_ready = (stall_left == 0);
      start = (cyc == start_at);
    end
    pix_valid = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      chk("no_timeout", 32'(done), 1);
      chk("n_windows", 32'(nwin), 15);
      chk("n_frame_done", 32'(nfd), 1);
      chk("n_accepts", 32'(k), W * H);
      chk("q_empty", 32'(acc_q.size() + win_q.size()), 0);
      chk("fd_gap", 32'((fd_cyc - last_acc) >= 2), 1);
    end
  endtask

  initial begin
    #12;
    chk_zero("rst0");
    @(negedge clk);
    reset = 1'b1;
    run_frame(1'b0, 1'b0, 0, -1);
    run_frame(1'b0, 1'b1, 0, -1);
    run_frame(1'b1, 1'b0, 0, -1);
    run_frame(1'b0, 1'b0, 30, -1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_frame(1'b0, 1'b0, 0, -1);
    run_frame(1'b1, 1'b0, 0, 25);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
